video_timing_gen: RTL

- Raster scan controller that sequences the video pixel pipeline.
- Generates pixel coordinates x/y, the visible flag, and hsync/vsync for one fixed mode per build.
- x, y and visible feed the test-pattern generator and later pixel sources.
- hsync/vsync go to the VGA pins through a programmable delay, so they line up with the pixel-source output register.
- Defaults give 1024x768@60 (65 MHz pixel rate).

---
 rtl/video_timing_gen_if.sv | 19 +
 rtl/video_timing_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: pixel coordinates, visible flag, syncs and pulses.
// master drives it (video_timing_gen), slave consumes it (pixel sources).
interface video_timing_gen_if;
    logic [15:0] x;
    logic [15:0] y;
    logic        visible;
    logic        hsync;
    logic        vsync;
    logic        line_start;
    logic        frame_start;

    modport master (
        output x, y, visible, hsync, vsync, line_start, frame_start
    );

    modport slave (
        input x, y, visible, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster scan controller: x/y counters, visible decode, delayed h/v sync.
// Ports: clk, reset (sync, active-high), ce (pixel advance), vo (timing bundle).
module video_timing_gen #(
    parameter int H_VISIBLE    = 1024,
    parameter int H_FRONT      = 24,
    parameter int H_SYNC       = 136,
    parameter int H_BACK       = 160,
    parameter int V_VISIBLE    = 768,
    parameter int V_FRONT      = 3,
    parameter int V_SYNC       = 6,
    parameter int V_BACK       = 29,
    parameter bit HSYNC_ACTIVE = 1'b0,
    parameter bit VSYNC_ACTIVE = 1'b0,
    parameter int SYNC_DELAY   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    video_timing_gen_if.master vo
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 65536 || V_TOTAL > 65536 ||
            SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_bad_params
            $error("video_timing_gen: illegal timing parameters");
        end
    endgenerate

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

    // Decode thresholds kept 32 bits wide so a 65536 bound still compares.
    localparam logic [31:0] HV     = 32'(H_VISIBLE);
    localparam logic [31:0] HS_BEG = 32'(H_VISIBLE + H_FRONT);
    localparam logic [31:0] HS_END = 32'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [31:0] VV     = 32'(V_VISIBLE);
    localparam logic [31:0] VS_BEG = 32'(V_VISIBLE + V_FRONT);
    localparam logic [31:0] VS_END = 32'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [15:0] x_q, y_q;
    logic [15:0] x_nxt, y_nxt;
    logic        vis_q, hs_q, vs_q, ls_q, fs_q;
    logic        vis_nxt, hs_nxt, vs_nxt, ls_nxt, fs_nxt;
    logic [31:0] xw, yw;

    always_comb begin
        x_nxt = x_q;
        y_nxt = y_q;
        if (ce) begin
            if (x_q != H_LAST) begin
                x_nxt = x_q + 16'd1;
            end else begin
                x_nxt = '0;
                y_nxt = (y_q == V_LAST) ? '0 : y_q + 16'd1;
            end
        end
    end

    // Decode from next-state so registered flags line up with x/y.
    always_comb begin
        xw      = {16'd0, x_nxt};
        yw      = {16'd0, y_nxt};
        vis_nxt = (xw < HV) && (yw < VV);
        hs_nxt  = (xw >= HS_BEG && xw < HS_END) ? HSYNC_ACTIVE
                                                : !HSYNC_ACTIVE;
        vs_nxt  = (yw >= VS_BEG && yw < VS_END) ? VSYNC_ACTIVE
                                                : !VSYNC_ACTIVE;
        ls_nxt  = ce && (x_nxt == '0);
        fs_nxt  = ls_nxt && (y_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= H_LAST;
            y_q   <= V_LAST;
            vis_q <= 1'b0;
            hs_q  <= !HSYNC_ACTIVE;
            vs_q  <= !VSYNC_ACTIVE;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            vis_q <= vis_nxt;
            hs_q  <= hs_nxt;
            vs_q  <= vs_nxt;
            ls_q  <= ls_nxt;
            fs_q  <= fs_nxt;
        end
    end

    assign vo.x           = x_q;
    assign vo.y           = y_q;
    assign vo.visible     = vis_q;
    assign vo.line_start  = ls_q;
    assign vo.frame_start = fs_q;

    // Sync delay runs on every clk so it tracks the pixel-source register,
    // not the ce-gated counters.
    generate
        if (SYNC_DELAY == 0) begin : g_no_dly
            assign vo.hsync = hs_q;
            assign vo.vsync = vs_q;
        end else begin : g_dly
            logic [SYNC_DELAY-1:0] hd, vd;

            always_ff @(posedge clk) begin
                if (reset) begin
                    hd <= {SYNC_DELAY{!HSYNC_ACTIVE}};
                    vd <= {SYNC_DELAY{!VSYNC_ACTIVE}};
                end else begin
                    hd <= SYNC_DELAY'({hd, hs_q});
                    vd <= SYNC_DELAY'({vd, vs_q});
                end
            end

            assign vo.hsync = hd[SYNC_DELAY-1];
            assign vo.vsync = vd[SYNC_DELAY-1];
        end
    endgenerate

endmodule
